// File: rtl/cfar_pkg.sv
// Shared cell type, FSM state and size helpers for the CA-CFAR detector.
package cfar_pkg;

  localparam int CELL_DATA_W = 32;
  localparam int CELL_IDX_W  = 16;

  typedef struct packed {
    logic [CELL_DATA_W-1:0] power;
    logic                   valid;
    logic [CELL_IDX_W-1:0]  idx;
    logic                   last;
  } cell_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic int calc_c(input int guard, input int train);
    return guard + train;
  endfunction

  function automatic int calc_w(input int guard, input int train);
    return 2 * (guard + train) + 1;
  endfunction

  function automatic int calc_ns_w(input int data_w, input int train);
    return data_w + $clog2(2 * train);
  endfunction

endpackage

// File: rtl/cfar_threshold_cmp.sv
// Detection decision: CUT power scaled by the training-cell count against
// noise_sum * alpha, compared strictly at full width.
module cfar_threshold_cmp
  import cfar_pkg::*;
#(
  parameter int DATA_W     = CELL_DATA_W,
  parameter int TRAIN      = 8,
  parameter int ALPHA_FRAC = 4,
  parameter int NS_W       = calc_ns_w(DATA_W, TRAIN)
) (
  input  logic [DATA_W-1:0] power,
  input  logic [NS_W-1:0]   noise_sum,
  input  logic [7:0]        alpha,
  input  logic              win_edge,
  output logic              det
);

  localparam int L_W   = $clog2(2 * TRAIN);
  localparam int CMP_W = NS_W + 8 + ALPHA_FRAC;

  logic [CMP_W-1:0] scaled_power;
  logic [CMP_W-1:0] scaled_noise;

  // Shifting by log2(2*TRAIN) turns the mean comparison into a sum comparison.
  assign scaled_power = CMP_W'(power) << (ALPHA_FRAC + L_W);
  assign scaled_noise = CMP_W'(noise_sum) * CMP_W'(alpha);
  assign det          = !win_edge && (scaled_power > scaled_noise);

endmodule

// File: rtl/ca_cfar_detector.sv
// CA-CFAR detector: delay line with running lead/lag training sums, a single-entry
// output register, and a bubble flush that drains the tail of each frame.
//
// state | meaning
// RUN   | accepting cells, one shift per accepted cell
// FLUSH | shifting bubbles in to emit the frame tail; input held off
module ca_cfar_detector
  import cfar_pkg::*;
#(
  parameter int  DATA_W     = CELL_DATA_W,
  parameter int  GUARD      = 2,
  parameter int  TRAIN      = 8,
  parameter int  IDX_W      = CELL_IDX_W,
  parameter int  ALPHA_FRAC = 4,
  localparam int NS_W       = calc_ns_w(DATA_W, TRAIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        alpha,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_power,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_power,
  output logic [NS_W-1:0]   out_noise_sum,
  output logic              out_det,
  output logic              out_edge,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  localparam int W     = calc_w(GUARD, TRAIN);
  localparam int C     = calc_c(GUARD, TRAIN);
  localparam int CNT_W = $clog2(C + 1);

  state_t            state, state_nx;
  cell_t             line [W];
  cell_t             new_cell;
  logic              run_en;
  logic              frame_start;
  logic [7:0]        alpha_q;
  logic [IDX_W-1:0]  idx_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [NS_W-1:0]   lead_sum, lag_sum, lead_nx, lag_nx, noise_nx;
  logic              shift, accept, flush_done, load, win_edge, det_nx;
  logic [DATA_W-1:0] cut_power;

  function automatic logic [NS_W-1:0] cell_val(input cell_t c);
    return c.valid ? NS_W'(c.power) : '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    shift      = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        in_ready = run_en && (!out_valid || out_ready);
        shift    = in_valid && in_ready;
        if (shift && in_last) state_nx = FLUSH;
      end
      FLUSH: begin
        shift = !out_valid || out_ready;
        if (shift && flush_cnt == CNT_W'(1)) begin
          flush_done = 1'b1;
          state_nx   = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign accept = (state == RUN) && shift;

  always_comb begin
    new_cell = '0;
    if (state == RUN) begin
      new_cell.power = CELL_DATA_W'(in_power);
      new_cell.valid = 1'b1;
      new_cell.idx   = CELL_IDX_W'(idx_cnt);
      new_cell.last  = in_last;
    end
  end

  // Post-shift sums and window occupancy, read from the pre-shift line.
  always_comb begin
    lead_nx  = lead_sum + cell_val(new_cell) - cell_val(line[TRAIN-1]);
    lag_nx   = lag_sum + cell_val(line[C+GUARD]) - cell_val(line[W-1]);
    noise_nx = lead_nx + lag_nx;
    win_edge = !new_cell.valid;
    for (int k = 0; k < TRAIN - 1; k++) win_edge = win_edge | !line[k].valid;
    for (int k = C + GUARD; k < W - 1; k++) win_edge = win_edge | !line[k].valid;
  end

  assign cut_power = DATA_W'(line[C-1].power);
  assign load      = shift && line[C-1].valid;

  cfar_threshold_cmp #(
    .DATA_W    (DATA_W),
    .TRAIN     (TRAIN),
    .ALPHA_FRAC(ALPHA_FRAC),
    .NS_W      (NS_W)
  ) u_cmp (
    .power    (cut_power),
    .noise_sum(noise_nx),
    .alpha    (alpha_q),
    .win_edge (win_edge),
    .det      (det_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < W; k++) line[k] <= '0;
      lead_sum <= '0;
      lag_sum  <= '0;
    end else if (shift) begin
      if (flush_done) begin
        for (int k = 0; k < W; k++) line[k] <= '0;
        lead_sum <= '0;
        lag_sum  <= '0;
      end else begin
        line[0] <= new_cell;
        for (int k = 1; k < W; k++) line[k] <= line[k-1];
        lead_sum <= lead_nx;
        lag_sum  <= lag_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en      <= 1'b0;
      frame_start <= 1'b1;
      alpha_q     <= '0;
      idx_cnt     <= '0;
      flush_cnt   <= '0;
    end else begin
      run_en <= 1'b1;
      if (accept) begin
        idx_cnt     <= in_last ? '0 : idx_cnt + IDX_W'(1);
        frame_start <= in_last;
        if (frame_start) alpha_q <= alpha;
        if (in_last) flush_cnt <= CNT_W'(C);
      end else if (state == FLUSH && shift) begin
        flush_cnt <= flush_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_power     <= '0;
      out_noise_sum <= '0;
      out_det       <= 1'b0;
      out_edge      <= 1'b0;
      out_idx       <= '0;
      out_last      <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_power     <= cut_power;
      out_noise_sum <= noise_nx;
      out_det       <= det_nx;
      out_edge      <= win_edge;
      out_idx       <= IDX_W'(line[C-1].idx);
      out_last      <= line[C-1].last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
